// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit producing the HI/LO pair.
// Shift-add multiply and restoring divide on operand magnitudes, one iteration per clock.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [W2-1:0] neg_2w(input logic [W2-1:0] v);
        return ~v + W2'(1);
    endfunction

    // -2^(W-1) maps to unsigned 2^(W-1), which still fits in WIDTH bits
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? neg_w(v) : v;
    endfunction

    state_t           state_r, state_s;
    logic             op_r, op_s;
    logic             sign_a_r, sign_a_s;
    logic             sign_b_r, sign_b_s;
    logic             dz_r, dz_s;
    logic [CW-1:0]    count_r, count_s;
    logic [WIDTH-1:0] operand_r, operand_s;
    logic [WIDTH:0]   work_hi_r, work_hi_s;
    logic [WIDTH-1:0] work_lo_r, work_lo_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             div_zero_r, div_zero_s;
    logic [WIDTH-1:0] hi_r, hi_s;
    logic [WIDTH-1:0] lo_r, lo_s;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   mul_hi_s;
    logic [WIDTH-1:0] mul_lo_s;
    logic [WIDTH:0]   div_trial_s;
    logic             div_ge_s;
    logic [WIDTH:0]   div_hi_s;
    logic [WIDTH-1:0] div_lo_s;
    logic [W2-1:0]    product_s;

    // One multiply step and one restoring-divide step over the work registers
    always_comb begin
        if (work_lo_r[0]) begin
            mul_sum_s = work_hi_r + {1'b0, operand_r};
        end else begin
            mul_sum_s = work_hi_r;
        end
        mul_hi_s    = {1'b0, mul_sum_s[WIDTH:1]};
        mul_lo_s    = {mul_sum_s[0], work_lo_r[WIDTH-1:1]};
        div_trial_s = {work_hi_r[WIDTH-1:0], work_lo_r[WIDTH-1]};
        div_ge_s    = (div_trial_s >= {1'b0, operand_r});
        if (div_ge_s) begin
            div_hi_s = div_trial_s - {1'b0, operand_r};
        end else begin
            div_hi_s = div_trial_s;
        end
        div_lo_s  = {work_lo_r[WIDTH-2:0], div_ge_s};
        product_s = {work_hi_r[WIDTH-1:0], work_lo_r};
    end

    // Next-state and next-output logic of the IDLE/RUN/FINISH controller
    always_comb begin
        state_s    = state_r;
        op_s       = op_r;
        sign_a_s   = sign_a_r;
        sign_b_s   = sign_b_r;
        dz_s       = dz_r;
        count_s    = count_r;
        operand_s  = operand_r;
        work_hi_s  = work_hi_r;
        work_lo_s  = work_lo_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        div_zero_s = 1'b0;
        hi_s       = hi_r;
        lo_s       = lo_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    op_s      = op;
                    sign_a_s  = a[WIDTH-1];
                    sign_b_s  = b[WIDTH-1];
                    count_s   = '0;
                    work_hi_s = '0;
                    busy_s    = 1'b1;
                    // operand_r holds the value added/subtracted each step,
                    // work_lo_r the value shifted out (multiplier or dividend)
                    if (op) begin
                        operand_s = magnitude(b);
                        work_lo_s = magnitude(a);
                    end else begin
                        operand_s = magnitude(a);
                        work_lo_s = magnitude(b);
                    end
                    if (op && (b == '0)) begin
                        dz_s    = 1'b1;
                        state_s = ST_FINISH;
                    end else begin
                        dz_s    = 1'b0;
                        state_s = ST_RUN;
                    end
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_RUN: begin
                count_s = count_r + CW'(1);
                if (op_r) begin
                    work_hi_s = div_hi_s;
                    work_lo_s = div_lo_s;
                end else begin
                    work_hi_s = mul_hi_s;
                    work_lo_s = mul_lo_s;
                end
                if (count_r == CW'(WIDTH - 1)) begin
                    state_s = ST_FINISH;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FINISH: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b1;
                if (dz_r) begin
                    div_zero_s = 1'b1;
                end else if (op_r) begin
                    // quotient truncates toward zero, remainder follows the dividend
                    lo_s = (sign_a_r ^ sign_b_r) ? neg_w(work_lo_r) : work_lo_r;
                    hi_s = sign_a_r ? neg_w(work_hi_r[WIDTH-1:0]) : work_hi_r[WIDTH-1:0];
                end else begin
                    {hi_s, lo_s} = (sign_a_r ^ sign_b_r) ? neg_2w(product_s) : product_s;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            op_r       <= 1'b0;
            sign_a_r   <= 1'b0;
            sign_b_r   <= 1'b0;
            dz_r       <= 1'b0;
            count_r    <= '0;
            operand_r  <= '0;
            work_hi_r  <= '0;
            work_lo_r  <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= '0;
            lo_r       <= '0;
        end else begin
            state_r    <= state_s;
            op_r       <= op_s;
            sign_a_r   <= sign_a_s;
            sign_b_r   <= sign_b_s;
            dz_r       <= dz_s;
            count_r    <= count_s;
            operand_r  <= operand_s;
            work_hi_r  <= work_hi_s;
            work_lo_r  <= work_lo_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            div_zero_r <= div_zero_s;
            hi_r       <= hi_s;
            lo_r       <= lo_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule
